// File: rtl/cyc_ctrl_pkg.sv
// Shared types and constants for the rk16 instruction-cycle controller.
package cyc_ctrl_pkg;

  localparam int unsigned XLEN_DEF = 16;
  localparam int unsigned ILEN_DEF = 32;
  localparam int unsigned NSTG     = 4;

  localparam int unsigned STG_IF = 0;
  localparam int unsigned STG_RD = 1;
  localparam int unsigned STG_EX = 2;
  localparam int unsigned STG_WB = 3;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    STEP   = 2'd3
  } state_t;

  // True when at most one bit of the stage vector is set.
  function automatic logic onehot0(input logic [NSTG-1:0] v);
    return (v & (v - NSTG'(1))) == '0;
  endfunction

endpackage

// File: rtl/cyc_ctrl_stg_chk.sv
// Stage-bus integrity check: flags a multi-hot stage vector or a strobe
// that does not match the current stage.
module stg_chk
  import cyc_ctrl_pkg::*;
(
  input  logic [NSTG-1:0] stage,
  input  logic [NSTG-1:0] stg_clk,
  output logic            multi_hot,
  output logic            err_now
);

  always_comb begin
    multi_hot = !onehot0(stage);
    err_now   = multi_hot || ((stg_clk != '0) && (stg_clk != stage));
  end

endmodule

// File: rtl/cyc_ctrl.sv
// Instruction-cycle controller: owns PC/IR and gates memory/register strobes
// by run state. Optional single-step support under CYC_CTRL_STEP_EN.
module cyc_ctrl
  import cyc_ctrl_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter int unsigned     ILEN     = ILEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSTG-1:0] stage,
  input  logic [NSTG-1:0] stg_clk,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            is_load,
  input  logic            is_store,
  input  logic            writes_rd,
  input  logic            is_jump,
  input  logic [XLEN-1:0] jump_tgt,
  input  logic            is_halt,
  input  logic            halt_req,
  input  logic            run_req,
`ifdef CYC_CTRL_STEP_EN
  input  logic            step_req,
`endif
  output logic [XLEN-1:0] imem_addr,
  output logic [ILEN-1:0] ir,
  output logic            dmem_re,
  output logic            dmem_we,
  output logic            rf_we,
  output logic            halted,
  output logic            stage_err
);

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc;
  logic            multi_hot, err_now, boundary, active;

  stg_chk u_stg_chk (
    .stage     (stage),
    .stg_clk   (stg_clk),
    .multi_hot (multi_hot),
    .err_now   (err_now)
  );

  assign boundary  = (stage == NSTG'(1)) && (stg_clk == '0);
  assign active    = (state == RUN) || (state == STEP);
  assign imem_addr = pc;

  // Next-state: a zero stage bus means the generator was re-reset.
  always_comb begin
    state_nxt = state;
    if (stage == '0) begin
      state_nxt = SYNC;
    end else begin
      case (state)
        SYNC: if (boundary) state_nxt = RUN;
        RUN: begin
          if (multi_hot)
            state_nxt = HALTED;
          else if (stg_clk[STG_WB] && (is_halt || halt_req || stage_err || err_now))
            state_nxt = HALTED;
        end
        HALTED: begin
          if (boundary) begin
            if (run_req && !halt_req)
              state_nxt = RUN;
`ifdef CYC_CTRL_STEP_EN
            else if (step_req && !run_req)
              state_nxt = STEP;
`endif
          end
        end
`ifdef CYC_CTRL_STEP_EN
        STEP: if (multi_hot || stg_clk[STG_WB]) state_nxt = HALTED;
`endif
        default: state_nxt = SYNC;
      endcase
    end
  end

  // Strobes follow the stage bus with no added latency.
  always_comb begin
    dmem_re = active && stage[STG_EX] && is_load;
    dmem_we = active && stg_clk[STG_EX] && is_store;
    rf_we   = active && stg_clk[STG_WB] && writes_rd;
    halted  = (state == HALTED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SYNC;
      pc        <= RESET_PC;
      ir        <= '0;
      stage_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (err_now) stage_err <= 1'b1;
      if (active && stg_clk[STG_IF]) ir <= imem_rdata;
      if (active && stg_clk[STG_WB]) pc <= is_jump ? jump_tgt : pc + XLEN'(1);
    end
  end

endmodule

// File: tb/tb_cyc_ctrl.sv
// Self-checking bench for cyc_ctrl: directed sequences, an error-detection
// vector table and a randomized run against a cycle-level reference model.
module tb_cyc_ctrl;
  import cyc_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  stage, stg_clk;
  logic [31:0] imem_rdata;
  logic        is_load, is_store, writes_rd, is_jump, is_halt, halt_req, run_req;
  logic [15:0] jump_tgt;
`ifdef CYC_CTRL_STEP_EN
  logic        step_req;
`endif
  logic [15:0] imem_addr;
  logic [31:0] ir;
  logic        dmem_re, dmem_we, rf_we, halted, stage_err;

  always #5 clk = ~clk;

  cyc_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .stage      (stage),
    .stg_clk    (stg_clk),
    .imem_rdata (imem_rdata),
    .is_load    (is_load),
    .is_store   (is_store),
    .writes_rd  (writes_rd),
    .is_jump    (is_jump),
    .jump_tgt   (jump_tgt),
    .is_halt    (is_halt),
    .halt_req   (halt_req),
    .run_req    (run_req),
`ifdef CYC_CTRL_STEP_EN
    .step_req   (step_req),
`endif
    .imem_addr  (imem_addr),
    .ir         (ir),
    .dmem_re    (dmem_re),
    .dmem_we    (dmem_we),
    .rf_we      (rf_we),
    .halted     (halted),
    .stage_err  (stage_err)
  );

  // Reference model: mode 0 = waiting for sync, 1 = running, 2 = halted, 3 = stepping.
  int          m_mode;
  logic [15:0] m_pc;
  logic [31:0] m_ir;
  logic        m_err;

  int vectors = 0;
  int miscompares = 0;
  int gpos = 0;
  int cnt_re, cnt_we, cnt_rf;
  logic step_in;

  typedef struct {
    logic [3:0] stage;
    logic [3:0] stg_clk;
    logic       exp_err;
  } err_vec_t;

  err_vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cycle();
    logic act, e_re, e_we, e_rf, bad, errn, wb, bnd;
    @(negedge clk);
`ifdef CYC_CTRL_STEP_EN
    step_in = step_req;
`else
    step_in = 1'b0;
`endif
    act  = (m_mode == 1) || (m_mode == 3);
    e_re = act && stage[2] && is_load;
    e_we = act && stg_clk[2] && is_store;
    e_rf = act && stg_clk[3] && writes_rd;
    chk("cycle", {11'd0, imem_addr, ir, dmem_re, dmem_we, rf_we, halted, stage_err},
        {11'd0, m_pc, m_ir, e_re, e_we, e_rf, (m_mode == 2), m_err});
    cnt_re += int'(dmem_re);
    cnt_we += int'(dmem_we);
    cnt_rf += int'(rf_we);
    if (rst) begin
      m_mode = 0; m_pc = 16'h0; m_ir = 32'h0; m_err = 1'b0;
    end else begin
      bad  = $countones(stage) > 1;
      errn = bad || ((stg_clk != 4'h0) && (stg_clk != stage));
      wb   = stg_clk[3];
      bnd  = (stage == 4'b0001) && (stg_clk == 4'h0);
      if (act && stg_clk[0]) m_ir = imem_rdata;
      if (act && wb) m_pc = is_jump ? jump_tgt : m_pc + 16'd1;
      if (stage == 4'h0) m_mode = 0;
      else if (m_mode == 0) begin
        if (bnd) m_mode = 1;
      end else if (m_mode == 1) begin
        if (bad || (wb && (is_halt || halt_req || m_err || errn))) m_mode = 2;
      end else if (m_mode == 2) begin
        if (bnd && run_req && !halt_req) m_mode = 1;
        else if (bnd && step_in && !run_req) m_mode = 3;
      end else begin
        if (bad || wb) m_mode = 2;
      end
      if (errn) m_err = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic gen_set();
    stage   = 4'(1 << (gpos / 2));
    stg_clk = (gpos % 2 == 1) ? stage : 4'h0;
    gpos    = (gpos + 1) % 8;
  endtask

  task automatic rot(input int n);
    for (int i = 0; i < n; i++) begin
      gen_set();
      cycle();
    end
  endtask

  task automatic clr_fields();
    is_load = 0; is_store = 0; writes_rd = 0; is_jump = 0; is_halt = 0;
    jump_tgt = 16'h0;
  endtask

  task automatic instr(input logic ld, input logic st, input logic wr, input logic jp,
                       input logic [15:0] tgt, input logic hlt, input logic [31:0] rd);
    is_load = ld; is_store = st; writes_rd = wr; is_jump = jp; jump_tgt = tgt;
    is_halt = hlt; imem_rdata = rd;
    cnt_re = 0; cnt_we = 0; cnt_rf = 0;
    rot(8);
    clr_fields();
  endtask

  task automatic do_reset();
    rst = 1; stage = 4'h0; stg_clk = 4'h0;
    cycle();
    rst = 0; gpos = 0;
  endtask

  initial begin
    rst = 1; stage = 4'h0; stg_clk = 4'h0; imem_rdata = 32'h0;
    clr_fields(); halt_req = 0; run_req = 0;
`ifdef CYC_CTRL_STEP_EN
    step_req = 0;
`endif
    cnt_re = 0; cnt_we = 0; cnt_rf = 0;
    repeat (2) @(posedge clk);
    #1;
    m_mode = 0; m_pc = 16'h0; m_ir = 32'h0; m_err = 1'b0;
    chk("reset_pc", imem_addr, 16'h0);
    chk("reset_ir", ir, 32'h0);
    do_reset();

    // Idle generator, then one normal instruction
    repeat (4) cycle();
    gpos = 0;
    instr(0, 0, 0, 0, 16'h0, 0, 32'hA5A5_0001);
    chk("t1_pc", imem_addr, 16'h1);
    chk("t1_ir", ir, 32'hA5A5_0001);

    // Store then load
    instr(0, 1, 0, 0, 16'h0, 0, 32'h0000_0002);
    chk("t2_store_we", cnt_we, 1);
    chk("t2_store_re", cnt_re, 0);
    instr(1, 0, 1, 0, 16'h0, 0, 32'h0000_0003);
    chk("t2_load_re", cnt_re, 2);
    chk("t2_load_rf", cnt_rf, 1);
    chk("t2_load_we", cnt_we, 0);

    // PC wrap and jump
    instr(0, 0, 0, 1, 16'hFFFF, 0, 32'h4);
    chk("t3_jmp_ffff", imem_addr, 16'hFFFF);
    instr(0, 0, 0, 0, 16'h0, 0, 32'h5);
    chk("t3_wrap", imem_addr, 16'h0000);
    instr(0, 0, 0, 1, 16'h0040, 0, 32'h6);
    chk("t3_jmp_40", imem_addr, 16'h0040);

    // Halt instruction, then halt/run arbitration
    instr(0, 0, 0, 0, 16'h0, 1, 32'h7);
    chk("t4_halted", halted, 1);
    chk("t4_halt_pc", imem_addr, 16'h0041);
    halt_req = 1; run_req = 1;
    instr(1, 1, 1, 0, 16'h0, 0, 32'h8);
    chk("t4_no_strobes", cnt_re + cnt_we + cnt_rf, 0);
    chk("t4_still_halted", halted, 1);
    halt_req = 0;
    instr(0, 0, 0, 0, 16'h0, 0, 32'h9);
    run_req = 0;
    chk("t4_resumed", halted, 0);
    chk("t4_resume_pc", imem_addr, 16'h0042);
    cnt_re = 0; cnt_we = 0; cnt_rf = 0;
    rot(4);
    halt_req = 1;
    rot(4);
    halt_req = 0;
    chk("t4_midreq_halt", halted, 1);
    chk("t4_midreq_pc", imem_addr, 16'h0043);
    run_req = 1;
    instr(0, 0, 0, 0, 16'h0, 0, 32'hA);
    run_req = 0;
    chk("t4_pc_44", imem_addr, 16'h0044);

    // Stage-bus glitch
    rot(2);
    gen_set();
    stage = 4'b0011;
    cycle();
    rot(5);
    chk("t5_err", stage_err, 1);
    chk("t5_halted", halted, 1);
    chk("t5_pc", imem_addr, 16'h0044);
    run_req = 1;
    instr(0, 0, 0, 0, 16'h0, 0, 32'hB);
    run_req = 0;
    chk("t5_err_sticky", stage_err, 1);
    chk("t5_rehalt", halted, 1);
    do_reset();
    chk("t5_err_clr", stage_err, 0);

    // Reset during a store's EX stage
    is_store = 1; imem_rdata = 32'hC;
    cnt_we = 0;
    rot(4);
    rst = 1;
    gen_set();
    cycle();
    rst = 0;
    rot(3);
    clr_fields();
    chk("t6_no_we", cnt_we, 0);
    chk("t6_pc", imem_addr, 16'h0);
    instr(0, 0, 0, 0, 16'h0, 0, 32'hD);
    chk("t6_recover_pc", imem_addr, 16'h1);

`ifdef CYC_CTRL_STEP_EN
    instr(0, 0, 0, 0, 16'h0, 1, 32'hE);
    step_req = 1;
    instr(0, 1, 0, 0, 16'h0, 0, 32'hF);
    step_req = 0;
    chk("step_we", cnt_we, 1);
    chk("step_pc", imem_addr, 16'h3);
    chk("step_halted", halted, 1);
    instr(0, 1, 0, 0, 16'h0, 0, 32'h10);
    chk("step_once", cnt_we, 0);
`endif

    // Error-detection table: one vector after a fresh reset, stage_err sampled next
    tbl[0] = '{4'b0001, 4'b0000, 1'b0};
    tbl[1] = '{4'b0001, 4'b0001, 1'b0};
    tbl[2] = '{4'b0010, 4'b0010, 1'b0};
    tbl[3] = '{4'b0000, 4'b0000, 1'b0};
    tbl[4] = '{4'b0011, 4'b0000, 1'b1};
    tbl[5] = '{4'b0100, 4'b1000, 1'b1};
    tbl[6] = '{4'b0000, 4'b0001, 1'b1};
    tbl[7] = '{4'b1111, 4'b0000, 1'b1};
    tbl[8] = '{4'b1000, 4'b1000, 1'b0};
    tbl[9] = '{4'b1000, 4'b0100, 1'b1};
    for (int i = 0; i < 10; i++) begin
      do_reset();
      stage = tbl[i].stage; stg_clk = tbl[i].stg_clk;
      cycle();
      chk($sformatf("tbl%0d", i), stage_err, tbl[i].exp_err);
    end

    // Randomized run against the model
    do_reset();
    begin
      int idle;
      idle = 0;
      for (int n = 0; n < 3000; n++) begin
        rst       = ($urandom_range(0, 299) == 0);
        is_load   = 1'($urandom);
        is_store  = 1'($urandom);
        writes_rd = 1'($urandom);
        is_jump   = ($urandom_range(0, 3) == 0);
        jump_tgt  = 16'($urandom);
        is_halt   = ($urandom_range(0, 15) == 0);
        halt_req  = ($urandom_range(0, 15) == 0);
        run_req   = 1'($urandom);
        imem_rdata = $urandom;
`ifdef CYC_CTRL_STEP_EN
        step_req  = 1'($urandom);
`endif
        if (idle == 0 && $urandom_range(0, 199) == 0) idle = $urandom_range(1, 5);
        if (idle > 0) begin
          stage = 4'h0; stg_clk = 4'h0; gpos = 0; idle--;
        end else begin
          gen_set();
          if ($urandom_range(0, 399) == 0) stage = 4'($urandom);
          if ($urandom_range(0, 399) == 0) stg_clk = 4'($urandom);
        end
        cycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
